mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 64, SHALL be the number of REQ-state cycles waited for mem_ack before the access is aborted.
REQ-002 clk  input  1  clock; all state SHALL change on the rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op_valid  input  1  CPU load/store request, sampled only in IDLE.
REQ-005 op_type  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
REQ-006 addr  input  32  byte address from CPU.
REQ-007 wdata  input  32  store data, low byte/half used for SB/SH.
REQ-008 busy  output  1  high whenever state != IDLE; CPU SHALL stall on it.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 rdata  output  32  extended load result, valid while done=1.
REQ-011 err  output  1  valid while done=1; access aborted.
REQ-012 mem_req  output  1  request to data memory.
REQ-013 mem_we  output  1  1 = store, 0 = load.
REQ-014 mem_addr  output  32  {addr[31:2],2'b00}.
REQ-015 mem_be  output  4  byte lane enables.
REQ-016 mem_wdata  output  32  lane-replicated store data.
REQ-017 mem_ack  input  1  memory accepted/completed the access.
REQ-018 mem_rdata  input  32  full word from memory, valid with mem_ack.

Function
REQ-019 States IDLE, REQ, DONE; all outputs registered or decoded from registered state only.
REQ-020 IDLE & op_valid at edge: latch op_type, addr, wdata; go REQ (mem_req=1 from next cycle).
REQ-021 REQ: hold mem_req, mem_we, mem_addr, mem_be, mem_wdata stable until mem_ack sampled high.
REQ-022 REQ & mem_ack at edge: capture/extend mem_rdata into rdata, err=0, go DONE; minimum latency op_valid edge to done = 2 cycles.
REQ-023 DONE: done=1 one cycle, then IDLE; op_valid in REQ/DONE SHALL be ignored (not queued).
REQ-024 Byte enables: SW/LW/LH/LHU/LB/LBU loads 1111; SH addr[1]=0 -> 0011, 1 -> 1100; SB 0001<<addr[1:0].
REQ-025 mem_wdata: SW wdata; SH {2{wdata[15:0]}}; SB {4{wdata[7:0]}}.
REQ-026 Load extraction: byte lane = mem_rdata[8*addr[1:0]+7 -: 8], half = mem_rdata[16*addr[1]+15 -: 16]; LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
REQ-027 Stores SHALL return rdata=0.
REQ-028 Timeout counter cleared on entering REQ, increments each REQ cycle without ack; at count TIMEOUT: drop mem_req, go DONE with err=1, rdata=0.
REQ-029 mem_ack outside REQ SHALL be ignored.

Reset
REQ-030 reset at edge SHALL force IDLE, busy=0, done=0, err=0, rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, counter=0, including mid-REQ (access abandoned, no done pulse).

Configuration
REQ-031 Macro MEM_ACCESS_ALIGN_CHECK_EN defined: in IDLE, LW/SW with addr[1:0]!=0 or LH/LHU/SH with addr[0]!=0 SHALL skip REQ (mem_req never asserted) and go directly to DONE with err=1, rdata=0.
REQ-032 Macro undefined: no alignment check; low address bits used only for lane selection per REQ-024/026; err arises only from timeout.

Verification
REQ-033 LB addr=0x0000_0003, mem_rdata=0x80FF_1234 ack immediately -> mem_be=1111, done 2 cycles after op, rdata=0xFFFF_FF80, err=0.
REQ-034 SH addr=0x0000_0102 wdata=0xDEAD_BEEF -> mem_addr=0x0000_0100, mem_be=1100, mem_wdata=0xBEEF_BEEF, mem_we=1, rdata=0.
REQ-035 LHU addr=0x0000_0000, ack delayed 5 cycles, mem_rdata=0x0000_9ABC -> mem_req held 6 cycles, signals stable, rdata=0x0000_9ABC.
REQ-036 LW, mem_ack never asserted, TIMEOUT=64 -> mem_req drops after 64 REQ cycles, done=1 err=1 rdata=0.
REQ-037 With MEM_ACCESS_ALIGN_CHECK_EN, SW addr=0x0000_0006 -> mem_req stays 0, done next cycle with err=1; without macro same op -> mem_addr=0x0000_0004, mem_be=1111.
REQ-038 reset asserted during REQ with mem_ack=1 same edge -> IDLE, all outputs 0, no done pulse.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// CPU load/store to data-memory access controller with lane steering, load extension and timeout.
// Define MEM_ACCESS_ALIGN_CHECK_EN to fail misaligned LW/SW/LH/LHU/SH without touching memory.
module mem_access_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_type,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t             state_q;
    logic [2:0]         op_q;
    logic [1:0]         lo_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               done_q;
    logic               err_q;
    logic [31:0]        rdata_q;
    logic               mem_req_q;
    logic               mem_we_q;
    logic [29:0]        mem_addr_q;
    logic [3:0]         mem_be_q;
    logic [31:0]        mem_wdata_q;

    function automatic logic is_store(input logic [2:0] op);
        return op[2] & (op[1] | op[0]);
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] op, input logic [1:0] lo);
        case (op)
            OP_SH:   return lo[1] ? 4'b1100 : 4'b0011;
            OP_SB:   return 4'b0001 << lo;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] op, input logic [31:0] wd);
        case (op)
            OP_SH:   return {2{wd[15:0]}};
            OP_SB:   return {4{wd[7:0]}};
            default: return wd;
        endcase
    endfunction

    // Stores fall through to zero so rdata reads 0 on store completion.
    function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] lo,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lo, 3'b000} +: 8];
        h = w[{lo[1], 4'b0000} +: 16];
        case (op)
            OP_LW:   return w;
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'h0000, h};
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'h000000, b};
            default: return 32'h0;
        endcase
    endfunction

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    function automatic logic misaligned(input logic [2:0] op, input logic [1:0] lo);
        case (op)
            OP_LW, OP_SW:         return lo != 2'b00;
            OP_LH, OP_LHU, OP_SH: return lo[0];
            default:              return 1'b0;
        endcase
    endfunction
`endif

    assign cnt_d = cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (op_valid) begin
                        op_q  <= op_type;
                        lo_q  <= addr[1:0];
                        cnt_q <= '0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
                        if (misaligned(op_type, addr[1:0])) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else
`endif
                        begin
                            state_q     <= REQ;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= is_store(op_type);
                            mem_addr_q  <= addr[31:2];
                            mem_be_q    <= lane_be(op_type, addr[1:0]);
                            mem_wdata_q <= lane_wdata(op_type, wdata);
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        err_q     <= 1'b0;
                        rdata_q   <= load_ext(op_q, lo_q, mem_rdata);
                        mem_req_q <= 1'b0;
                    end else if (cnt_d == CNT_W'(TIMEOUT)) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                        rdata_q   <= '0;
                        mem_req_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = {mem_addr_q, 2'b00};
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: lane steering, load extension, ack delay, timeout, reset.
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op_type;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op_type   (op_type),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_ctl"}, 32'({busy, done, err, mem_req, mem_we, mem_be}), 32'h0);
        check_val({tag, "_rdata"}, rdata, 32'h0);
        check_val({tag, "_maddr"}, mem_addr, 32'h0);
        check_val({tag, "_mwdata"}, mem_wdata, 32'h0);
    endtask

    // ack_delay = ack-less REQ cycles before ack; negative means never ack.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] mrd, input int ack_delay,
                          input logic hold, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_rd,
                          input logic exp_err, input int exp_reqc);
        logic [68:0] snap;
        logic        stable;
        logic        is_st;
        int          n;
        int          reqc;
        is_st     = op[2] & (op[1] | op[0]);
        op_valid  = 1'b1;
        op_type   = op;
        addr      = a;
        wdata     = wd;
        mem_ack   = 1'b0;
        mem_rdata = mrd;
        tick;
        if (hold) begin
            op_type = 3'b111;
            addr    = a ^ 32'h0000_0003;
            wdata   = ~wd;
        end else begin
            op_valid = 1'b0;
        end
        check_val({tag, "_req"}, 32'(mem_req), 32'h1);
        check_val({tag, "_we"}, 32'(mem_we), 32'(is_st));
        check_val({tag, "_maddr"}, mem_addr, exp_addr);
        check_val({tag, "_be"}, 32'(mem_be), 32'(exp_be));
        if (is_st) check_val({tag, "_mwdata"}, mem_wdata, exp_wd);
        snap   = {mem_we, mem_addr, mem_be, mem_wdata};
        stable = 1'b1;
        reqc   = 0;
        n      = 0;
        while (!done && n < TIMEOUT + 8) begin
            if (mem_req) reqc++;
            if ({mem_we, mem_addr, mem_be, mem_wdata} != snap) stable = 1'b0;
            mem_ack = (ack_delay >= 0) && (n >= ack_delay);
            tick;
            n++;
        end
        mem_ack = 1'b0;
        check_val({tag, "_done"}, 32'(done), 32'h1);
        check_val({tag, "_err"}, 32'(err), 32'(exp_err));
        check_val({tag, "_rdata"}, rdata, exp_rd);
        check_val({tag, "_reqcyc"}, reqc, exp_reqc);
        check_val({tag, "_stable"}, 32'(stable), 32'h1);
        check_val({tag, "_reqdrop"}, 32'(mem_req), 32'h0);
        op_valid = 1'b0;
        tick;
        check_val({tag, "_pulse"}, 32'({done, busy}), 32'h0);
        tick;
        check_val({tag, "_noqueue"}, 32'(busy), 32'h0);
    endtask

    initial begin
        reset     = 1'b1;
        op_valid  = 1'b0;
        op_type   = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        tick;
        tick;
        reset = 1'b0;
        check_idle("reset");

        run_op("LB_a3", 3'b011, 32'h0000_0003, 32'h0, 32'h80FF_1234, 0, 1'b0,
               32'h0, 4'hF, 32'h0, 32'hFFFF_FF80, 1'b0, 1);
        run_op("SH_a102", 3'b110, 32'h0000_0102, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1'b0,
               32'h0000_0100, 4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0, 1);
        run_op("LHU_dly5", 3'b010, 32'h0000_0000, 32'h0, 32'h0000_9ABC, 5, 1'b1,
               32'h0, 4'hF, 32'h0, 32'h0000_9ABC, 1'b0, 6);
        run_op("LH_a2", 3'b001, 32'h0000_0022, 32'h0, 32'h8001_1111, 2, 1'b0,
               32'h0000_0020, 4'hF, 32'h0, 32'hFFFF_8001, 1'b0, 3);
        run_op("LBU_a1", 3'b100, 32'h0000_0031, 32'h0, 32'h0000_F000, 0, 1'b0,
               32'h0000_0030, 4'hF, 32'h0, 32'h0000_00F0, 1'b0, 1);
        run_op("SB_a202", 3'b111, 32'h0000_0202, 32'h0000_00A5, 32'hFFFF_FFFF, 1, 1'b0,
               32'h0000_0200, 4'b0100, 32'hA5A5_A5A5, 32'h0, 1'b0, 2);
        run_op("SW_a8", 3'b101, 32'h0000_0008, 32'h1122_3344, 32'h0, 0, 1'b0,
               32'h0000_0008, 4'hF, 32'h1122_3344, 32'h0, 1'b0, 1);
        run_op("LW_a10", 3'b000, 32'h0000_0010, 32'h0, 32'hCAFE_BABE, 0, 1'b0,
               32'h0000_0010, 4'hF, 32'h0, 32'hCAFE_BABE, 1'b0, 1);
        run_op("LW_tmo", 3'b000, 32'h0000_0044, 32'h0, 32'hCAFE_BABE, -1, 1'b0,
               32'h0000_0044, 4'hF, 32'h0, 32'h0, 1'b1, TIMEOUT);

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        op_valid = 1'b1;
        op_type  = 3'b101;
        addr     = 32'h0000_0006;
        wdata    = 32'h1122_3344;
        tick;
        op_valid = 1'b0;
        check_val("SW_mis_req", 32'(mem_req), 32'h0);
        check_val("SW_mis_done", 32'({done, err}), 32'h3);
        check_val("SW_mis_rdata", rdata, 32'h0);
        tick;
        check_val("SW_mis_idle", 32'({busy, done, mem_req}), 32'h0);
`else
        run_op("SW_mis", 3'b101, 32'h0000_0006, 32'h1122_3344, 32'h0, 0, 1'b0,
               32'h0000_0004, 4'hF, 32'h1122_3344, 32'h0, 1'b0, 1);
`endif

        op_valid = 1'b1;
        op_type  = 3'b000;
        addr     = 32'h0000_0040;
        tick;
        op_valid = 1'b0;
        check_val("rstREQ_req", 32'(mem_req), 32'h1);
        tick;
        mem_ack = 1'b1;
        reset   = 1'b1;
        tick;
        check_idle("rstREQ");
        reset   = 1'b0;
        mem_ack = 1'b0;
        tick;
        check_idle("rstREQ_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
